// File: rtl/dmem_map_pkg.sv
// Address map, MMIO register selects and STATUS layout shared by the data-memory responder.
package dmem_map_pkg;

    localparam logic [4:0]  OFF_CYCLE  = 5'h00;
    localparam logic [4:0]  OFF_TOHOST = 5'h08;
    localparam logic [4:0]  OFF_TXDATA = 5'h10;
    localparam logic [4:0]  OFF_TXSTAT = 5'h18;
    localparam logic [63:0] MMIO_SPAN  = 64'h20;

    // Register select is the 8-byte word index inside the window (A[4:3]).
    localparam logic [1:0] SEL_CYCLE  = OFF_CYCLE[4:3];
    localparam logic [1:0] SEL_TOHOST = OFF_TOHOST[4:3];
    localparam logic [1:0] SEL_TXDATA = OFF_TXDATA[4:3];
    localparam logic [1:0] SEL_TXSTAT = OFF_TXSTAT[4:3];

    // STATUS: count in [3:0], bit 4 reserved zero, then empty, full, overflow.
    localparam int ST_CNT_LSB = 0;
    localparam int ST_EMPTY   = 5;
    localparam int ST_FULL    = 6;
    localparam int ST_OVF     = 7;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_UNMAPPED
    } region_e;

    function automatic logic [63:0] status_word(input logic ovf, input logic full,
                                                input logic empty, input logic [3:0] cnt);
        logic [63:0] w;
        w                         = '0;
        w[ST_CNT_LSB +: 4]        = cnt;
        w[ST_EMPTY]               = empty;
        w[ST_FULL]                = full;
        w[ST_OVF]                 = ovf;
        return w;
    endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Circular byte FIFO feeding a valid/ready consumer, with a sticky overflow flag for rejected pushes.
module tx_byte_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          clr_ovf,
    input  logic                          tx_ready,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          pop, push_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = ovf_q;

    always_comb begin
        pop      = tx_valid && tx_ready;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        push_ok  = push && (!full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (clr_ovf)
            ovf_d = 1'b0;
        else if (push && !push_ok)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && rst_n)
            mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core: word RAM, cycle counter, tohost/halt and a TX byte FIFO behind MMIO.
module dmem_responder
    import dmem_map_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter logic [63:0] MMIO_BASE  = 64'h0000_0000_1000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] DMEM_address,
    input  logic [63:0] DMEM_WriteData,
    input  logic        DMEM_MemWrite,
    input  logic        DMEM_MemRead,
    output logic [63:0] DMEM_ReadData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic [63:0] tohost,
    output logic        bus_err
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [63:0] RAM_BYTES = 64'(RAM_WORDS) * 64'd8;
    localparam logic [63:0] MMIO_END  = MMIO_BASE + MMIO_SPAN;

    logic [63:0] ram_q [RAM_WORDS];
    logic [63:0] cycle_q, cycle_d;
    logic [63:0] tohost_q, tohost_d;
    logic        halt_q, halt_d;
    logic        bus_err_q, bus_err_d;

    region_e     region;
    logic [AW-1:0] word_idx;
    logic [1:0]  reg_sel;
    logic        access_err;
    logic        ram_we, fifo_push, fifo_clr_ovf;

    logic                        fifo_full, fifo_empty, fifo_ovf;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [3:0]                  status_cnt;

    always_comb begin
        if (DMEM_address < RAM_BYTES)
            region = REG_RAM;
        else if (DMEM_address >= MMIO_BASE && DMEM_address < MMIO_END)
            region = REG_MMIO;
        else
            region = REG_UNMAPPED;
        word_idx   = DMEM_address[AW+2:3];
        reg_sel    = DMEM_address[4:3];
        // Low address bits are dropped for mapped accesses; they only raise the error flag.
        access_err = (DMEM_MemRead || DMEM_MemWrite) &&
                     (region == REG_UNMAPPED || DMEM_address[2:0] != 3'b000);
        ram_we       = rst && DMEM_MemWrite && region == REG_RAM;
        fifo_push    = DMEM_MemWrite && region == REG_MMIO && reg_sel == SEL_TXDATA;
        fifo_clr_ovf = DMEM_MemWrite && region == REG_MMIO && reg_sel == SEL_TXSTAT;
    end

    assign status_cnt = 4'(fifo_count);

    always_comb begin
        DMEM_ReadData = '0;
        if (DMEM_MemRead) begin
            case (region)
                REG_RAM:  DMEM_ReadData = ram_q[word_idx];
                REG_MMIO: begin
                    case (reg_sel)
                        SEL_CYCLE:  DMEM_ReadData = cycle_q;
                        SEL_TOHOST: DMEM_ReadData = tohost_q;
                        SEL_TXSTAT: DMEM_ReadData = status_word(fifo_ovf, fifo_full,
                                                                fifo_empty, status_cnt);
                        default:    DMEM_ReadData = '0;
                    endcase
                end
                default:  DMEM_ReadData = '0;
            endcase
        end
    end

    always_comb begin
        cycle_d   = cycle_q + 64'd1;
        tohost_d  = tohost_q;
        halt_d    = halt_q;
        bus_err_d = bus_err_q || access_err;
        if (DMEM_MemWrite && region == REG_MMIO && reg_sel == SEL_TOHOST) begin
            tohost_d = DMEM_WriteData;
            halt_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q   <= '0;
            tohost_q  <= '0;
            halt_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            tohost_q  <= tohost_d;
            halt_q    <= halt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // RAM contents survive reset; only stores seen while out of reset land.
    always_ff @(posedge clk) begin
        if (ram_we)
            ram_q[word_idx] <= DMEM_WriteData;
    end

    tx_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (fifo_push),
        .push_data (DMEM_WriteData[7:0]),
        .clr_ovf   (fifo_clr_ovf),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .overflow  (fifo_ovf)
    );

    assign halt    = halt_q;
    assign tohost  = tohost_q;
    assign bus_err = bus_err_q;

endmodule
